// File: rtl/demultiplexor_1x4_buffered.sv
// 1-to-4 demultiplexor with a single-entry valid/ready slot per output channel
// and a saturating per-channel count of accepted words.
module demultiplexor_1x4_buffered #(
    parameter int unsigned BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_data,
    input  logic [1:0]           control,
    output logic                 out_valid0,
    output logic                 out_valid1,
    output logic                 out_valid2,
    output logic                 out_valid3,
    input  logic                 out_ready0,
    input  logic                 out_ready1,
    input  logic                 out_ready2,
    input  logic                 out_ready3,
    output logic [BIT_WIDTH-1:0] out0,
    output logic [BIT_WIDTH-1:0] out1,
    output logic [BIT_WIDTH-1:0] out2,
    output logic [BIT_WIDTH-1:0] out3,
    input  logic                 count_clear,
    output logic [7:0]           count0,
    output logic [7:0]           count1,
    output logic [7:0]           count2,
    output logic [7:0]           count3
);

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(255);

    logic [NUM_CH-1:0]    valid_q, valid_d;
    logic [BIT_WIDTH-1:0] data_q  [NUM_CH];
    logic [BIT_WIDTH-1:0] data_d  [NUM_CH];
    logic [CNT_W-1:0]     count_q [NUM_CH];
    logic [CNT_W-1:0]     count_d [NUM_CH];
    logic [NUM_CH-1:0]    ready_sel;
    logic                 accept;

    assign ready_sel = {out_ready3, out_ready2, out_ready1, out_ready0};

    // Slot is free for the addressed channel if empty or draining this edge.
    always_comb begin
        in_ready = !valid_q[control] || ready_sel[control];
        accept   = in_valid && in_ready;
        for (int i = 0; i < NUM_CH; i++) begin
            valid_d[i] = valid_q[i];
            data_d[i]  = data_q[i];
            count_d[i] = count_q[i];
            if (valid_q[i] && ready_sel[i]) begin
                valid_d[i] = 1'b0;
            end
            if (accept && (control == 2'(i))) begin
                valid_d[i] = 1'b1;
                data_d[i]  = in_data;
                if (count_q[i] != CNT_MAX) begin
                    count_d[i] = count_q[i] + CNT_W'(1);
                end
            end
            if (count_clear) begin
                count_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                data_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < NUM_CH; i++) begin
                data_q[i]  <= data_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

    assign out_valid0 = valid_q[0];
    assign out_valid1 = valid_q[1];
    assign out_valid2 = valid_q[2];
    assign out_valid3 = valid_q[3];
    assign out0       = data_q[0];
    assign out1       = data_q[1];
    assign out2       = data_q[2];
    assign out3       = data_q[3];
    assign count0     = count_q[0];
    assign count1     = count_q[1];
    assign count2     = count_q[2];
    assign count3     = count_q[3];

endmodule

// File: tb/tb_demultiplexor_1x4_buffered.sv
// Directed self-checking bench for demultiplexor_1x4_buffered.
module tb_demultiplexor_1x4_buffered;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  control;
    logic        out_valid0, out_valid1, out_valid2, out_valid3;
    logic        out_ready0, out_ready1, out_ready2, out_ready3;
    logic [31:0] out0, out1, out2, out3;
    logic        count_clear;
    logic [7:0]  count0, count1, count2, count3;

    int total = 0;
    int bad   = 0;

    logic [3:0]  ov;
    logic [31:0] od [4];
    logic [7:0]  oc [4];

    assign ov    = {out_valid3, out_valid2, out_valid1, out_valid0};
    assign od[0] = out0;
    assign od[1] = out1;
    assign od[2] = out2;
    assign od[3] = out3;
    assign oc[0] = count0;
    assign oc[1] = count1;
    assign oc[2] = count2;
    assign oc[3] = count3;

    demultiplexor_1x4_buffered #(.BIT_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .control(control),
        .out_valid0(out_valid0), .out_valid1(out_valid1),
        .out_valid2(out_valid2), .out_valid3(out_valid3),
        .out_ready0(out_ready0), .out_ready1(out_ready1),
        .out_ready2(out_ready2), .out_ready3(out_ready3),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .count_clear(count_clear),
        .count0(count0), .count1(count1), .count2(count2), .count3(count3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic [3:0] r);
        {out_ready3, out_ready2, out_ready1, out_ready0} = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; control = '0;
        count_clear = 1'b0; set_ready(4'b0000);

        // Reset held: everything zero, in_ready 1 for every channel, no accept
        tick();
        chk("rst_valid", 32'(ov), 32'h0);
        for (int c = 0; c < 4; c++) begin
            chk("rst_data", od[c], 32'h0);
            chk("rst_count", 32'(oc[c]), 32'h0);
            control = 2'(c);
            #1;
            chk("rst_in_ready", 32'(in_ready), 32'h1);
        end
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF; control = 2'd1;
        tick();
        chk("rst_no_accept_valid", 32'(ov), 32'h0);
        chk("rst_no_accept_count", 32'(count1), 32'h0);
        in_valid = 1'b0;
        #2 reset = 1'b0;

        // First word to channel 2, consumer stalled
        tick();
        in_valid = 1'b1; control = 2'd2; in_data = 32'hDEAD_BEEF;
        tick();
        in_valid = 1'b0;
        chk("w1_valid", 32'(ov), 32'h4);
        chk("w1_out2", out2, 32'hDEAD_BEEF);
        chk("w1_count2", 32'(count2), 32'd1);

        // Second word to full stalled slot, then release
        in_valid = 1'b1; in_data = 32'h1234_5678;
        #1;
        chk("stall_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("stall_out2", out2, 32'hDEAD_BEEF);
        chk("stall_valid", 32'(ov), 32'h4);
        chk("stall_count2", 32'(count2), 32'd1);
        out_ready2 = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0; out_ready2 = 1'b0;
        chk("refill_out2", out2, 32'h1234_5678);
        chk("refill_valid", 32'(ov), 32'h4);
        chk("refill_count2", 32'(count2), 32'd2);

        // Drain leaves data in place
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        chk("drain_valid", 32'(ov), 32'h0);
        chk("drain_hold_out2", out2, 32'h1234_5678);

        // Clear counters, then stream 8 words with all consumers ready
        count_clear = 1'b1;
        tick();
        count_clear = 1'b0;
        for (int c = 0; c < 4; c++) chk("clear_count", 32'(oc[c]), 32'h0);
        set_ready(4'b1111);
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; control = 2'(k % 4); in_data = 32'hA000_0000 + 32'(k);
            #1;
            chk("stream_in_ready", 32'(in_ready), 32'h1);
            tick();
            chk("stream_valid", 32'(ov[k % 4]), 32'h1);
            chk("stream_data", od[k % 4], 32'hA000_0000 + 32'(k));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", 32'(ov), 32'h0);
        for (int c = 0; c < 4; c++) chk("stream_count", 32'(oc[c]), 32'd2);

        // 300 accepts to channel 0: count saturates at 255
        in_valid = 1'b1; control = 2'd0;
        for (int k = 0; k < 300; k++) begin
            in_data = 32'(k);
            tick();
        end
        chk("sat_count0", 32'(count0), 32'd255);
        chk("sat_out0", out0, 32'd299);
        tick();
        chk("sat_hold", 32'(count0), 32'd255);
        count_clear = 1'b1; in_data = 32'h0000_C1EA;
        tick();
        count_clear = 1'b0; in_valid = 1'b0;
        chk("clear_prio_count0", 32'(count0), 32'd0);
        chk("clear_accept_out0", out0, 32'h0000_C1EA);
        chk("clear_accept_valid0", 32'(out_valid0), 32'h1);

        // Slot 3 stalled full; channels 0 and 1 keep flowing
        set_ready(4'b0011);
        in_valid = 1'b1; control = 2'd3; in_data = 32'h3333_3333;
        tick();
        chk("s3_fill", out3, 32'h3333_3333);
        #1;
        chk("s3_full_in_ready", 32'(in_ready), 32'h0);
        control = 2'd0; in_data = 32'h4444_4444;
        #1;
        chk("ch0_in_ready", 32'(in_ready), 32'h1);
        tick();
        control = 2'd1; in_data = 32'h5555_5555;
        #1;
        chk("ch1_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("s3_hold_data", out3, 32'h3333_3333);
        chk("s3_hold_valid", 32'(out_valid3), 32'h1);
        chk("ch0_data", out0, 32'h4444_4444);
        chk("ch1_data", out1, 32'h5555_5555);
        chk("count3", 32'(count3), 32'd1);

        // Slot 1 stalled full, async reset between edges
        set_ready(4'b0000);
        #2;
        chk("pre_rst_valid1", 32'(out_valid1), 32'h1);
        reset = 1'b1;
        #1;
        chk("async_valid", 32'(ov), 32'h0);
        chk("async_out1", out1, 32'h0);
        chk("async_out3", out3, 32'h0);
        chk("async_count0", 32'(count0), 32'h0);
        chk("async_count3", 32'(count3), 32'h0);
        #1 reset = 1'b0;

        // Idle after reset, then a normal accept
        tick();
        chk("post_rst_valid", 32'(ov), 32'h0);
        in_valid = 1'b1; control = 2'd0; in_data = 32'h0000_0099;
        tick();
        in_valid = 1'b0;
        chk("post_rst_out0", out0, 32'h0000_0099);
        chk("post_rst_count0", 32'(count0), 32'd1);
        chk("post_rst_valid0", 32'(ov), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demultiplexor_1x4_buffered.md
DEMULTIPLEXOR_1X4_BUFFERED -- requirements
Module: demultiplexor_1x4_buffered

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32: width of each data word.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream word present.
REQ-005 SHALL have port in_ready  output  1  block accepts word this cycle.
REQ-006 SHALL have port in_data  input  BIT_WIDTH  upstream word.
REQ-007 SHALL have port control  input  2  destination channel (0..3) for in_data.
REQ-008 SHALL have ports out_valid0..out_valid3  output  1 each  channel slot holds a word.
REQ-009 SHALL have ports out_ready0..out_ready3  input  1 each  channel consumer takes word.
REQ-010 SHALL have ports out0..out3  output  BIT_WIDTH each  channel slot data.
REQ-011 SHALL have port count_clear  input  1  synchronous clear of all channel counters.
REQ-012 SHALL have ports count0..count3  output  8 each  words accepted per channel.

Function
REQ-013 SHALL hold one slot register (valid bit + BIT_WIDTH data) per channel; no other buffering.
REQ-014 SHALL drive in_ready combinationally = !out_validN || out_readyN, N = control; no dependence on in_valid.
REQ-015 SHALL accept a word when in_valid && in_ready at a rising edge; control sampled only then.
REQ-016 Accept to channel N SHALL load outN = in_data and set out_validN = 1 at that edge (visible next cycle; latency 1 cycle).
REQ-017 Slot N SHALL drain when out_validN && out_readyN at a rising edge; out_validN clears unless refilled same edge.
REQ-018 Simultaneous drain and accept on channel N SHALL leave out_validN = 1 with outN = new in_data (full throughput, one word/cycle/channel).
REQ-019 While out_validN && !out_readyN, outN and out_validN SHALL stay stable.
REQ-020 Accept on channel N SHALL not alter slot state of any other channel; other channels drain independently same cycle.
REQ-021 When out_validN = 0, outN SHALL hold its last loaded value (zero after reset).
REQ-022 in_valid with in_ready = 0 SHALL change no state; upstream holds word (stall).
REQ-023 countN SHALL increment by 1 per accepted word to channel N, saturating at 255 (no wrap).
REQ-024 count_clear = 1 SHALL zero all counters at the edge, taking priority over a same-edge increment.
REQ-025 out_readyN with out_validN = 0 SHALL have no effect.

Reset
REQ-026 reset = 1 SHALL immediately, independent of clk, force out_valid0..3 = 0, out0..3 = 0, count0..3 = 0.
REQ-027 With reset held, in_ready SHALL read 1 for every control value and no accept SHALL occur.
REQ-028 Reset asserted mid-transfer SHALL discard slot contents; first edge after deassertion behaves as post-reset idle.

Verification
REQ-029 Reset, then in_valid=1, control=2, in_data=0xDEADBEEF, out_ready2=0 -> next cycle out_valid2=1, out2=0xDEADBEEF, count2=1; other valids 0.
REQ-030 Slot 2 full, out_ready2=0, second word control=2 -> in_ready=0, out2 unchanged, count2 stays 1; raise out_ready2 -> in_ready=1, accept, out2=new word, out_valid2 stays 1.
REQ-031 All out_ready=1, stream 8 words control=0,1,2,3,0,1,2,3 one per cycle -> in_ready=1 every cycle, each word appears on its channel one cycle later, count0..3 = 2.
REQ-032 out_ready0=1 continuously, 300 accepts to channel 0 -> count0 = 255 and holds; count_clear pulse with same-edge accept -> count0 = 0.
REQ-033 Slot 1 full, stalled; assert reset asynchronously between edges -> out_valid1=0, out1=0, counts 0 before next edge.
REQ-034 Slot 3 full, stalled; accepts to channels 0 and 1 -> in_ready=1 for those, slot 3 data and valid unchanged throughout.
